// File: rtl/boot_seq_pkg.sv
// Shared types for the boot sequencer: FSM state encoding and its width.
package boot_seq_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StLoad  = 2'd0,
        StFlush = 2'd1,
        StRun   = 2'd2,
        StHalt  = 2'd3
    } boot_state_e;

endpackage

// File: rtl/byte_packer.sv
// Byte-to-word packer: a lane counter plus a 32-bit little-endian assembly register.
// Unfilled lanes of the assembly register are always zero, so o_word doubles as the
// zero-padded partial word when the image ends mid-word.
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_clear,
    output logic        o_word_complete,
    output logic        o_partial,
    output logic [31:0] o_word
);

    logic [1:0]  r_lane;
    logic [31:0] r_word;
    logic [1:0]  w_lane_next;
    logic [31:0] w_word_merged;

    // Merge the byte being accepted this cycle into its lane.
    always_comb begin
        w_word_merged = r_word;
        w_lane_next   = r_lane + 2'(i_accept);
        if (i_accept) begin
            w_word_merged[8*r_lane +: 8] = i_byte;
        end
        o_word_complete = i_accept && (r_lane == 2'd3);
        o_partial       = (w_lane_next != 2'd0);
        o_word          = w_word_merged;
    end

    // Lane counter and assembly register; cleared once a word is handed off.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_lane <= 2'd0;
            r_word <= 32'd0;
        end else if (i_accept) begin
            r_lane <= w_lane_next;
            r_word <= o_word_complete ? 32'd0 : w_word_merged;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer: loads a byte-stream program image into instruction memory while
// holding the core in reset, then runs the core for a bounded window and halts it.
// Optional feature macro: BOOT_SEQ_PARTIAL_WORD_EN (flush a trailing partial word,
// zero-padded, instead of discarding it).
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned RUN_CYCLES = 300
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              byte_valid,
    input  logic [7:0]                        byte_data,
    output logic                              byte_ready,
    input  logic                              load_done,
    input  logic                              halt_req,
    output logic                              imem_we,
    output logic [31:0]                       imem_addr,
    output logic [31:0]                       imem_wdata,
    output logic                              cpu_reset,
    output logic                              cpu_enable,
    output logic                              halted,
    output logic [$clog2(IMEM_DEPTH+1)-1:0]   words_loaded,
    output logic [$clog2(RUN_CYCLES+1)-1:0]   cycle_count
);

    localparam int unsigned WlWidth = $clog2(IMEM_DEPTH + 1);
    localparam int unsigned CcWidth = $clog2(RUN_CYCLES + 1);
    localparam logic [WlWidth-1:0] WlFull = WlWidth'(IMEM_DEPTH);
    localparam logic [CcWidth-1:0] CcLast = CcWidth'(RUN_CYCLES - 1);

    boot_state_e        r_state;
    boot_state_e        w_state_next;
    logic [WlWidth-1:0] r_words_loaded;
    logic [CcWidth-1:0] r_cycle_count;
    logic               r_imem_we;
    logic [31:0]        r_imem_addr;
    logic [31:0]        r_imem_wdata;

    logic        w_full;
    logic        w_byte_ready;
    logic        w_accept;
    logic        w_load_end;
    logic        w_word_complete;
    logic        w_partial;
    logic [31:0] w_packed_word;
    logic        w_flush_write;
    logic        w_do_write;

    assign w_full       = (r_words_loaded == WlFull);
    assign w_byte_ready = (r_state == StLoad) && !w_full;
    assign w_accept     = byte_valid && w_byte_ready;
    assign w_load_end   = (r_state == StLoad) && load_done;

    byte_packer u_byte_packer (
        .clock           (clock),
        .reset           (reset),
        .i_accept        (w_accept),
        .i_byte          (byte_data),
        .i_clear         (w_load_end),
        .o_word_complete (w_word_complete),
        .o_partial       (w_partial),
        .o_word          (w_packed_word)
    );

`ifdef BOOT_SEQ_PARTIAL_WORD_EN
    // Trailing bytes (including one accepted alongside load_done) become a padded word.
    assign w_flush_write = w_load_end && w_partial && !w_full;
`else
    assign w_flush_write = 1'b0;
`endif

    // A same-cycle full word and partial flush cannot coincide: completion empties the packer.
    assign w_do_write = (w_accept && w_word_complete) || w_flush_write;

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StLoad:  if (load_done) w_state_next = StFlush;
            StFlush: w_state_next = StRun;
            StRun:   if (halt_req || (r_cycle_count == CcLast)) w_state_next = StHalt;
            StHalt:  w_state_next = StHalt;
            default: w_state_next = StLoad;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StLoad;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Write port, load counter and run-window counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_words_loaded <= '0;
            r_cycle_count  <= '0;
            r_imem_we      <= 1'b0;
            r_imem_addr    <= 32'd0;
            r_imem_wdata   <= 32'd0;
        end else begin
            r_imem_we <= w_do_write;
            if (w_do_write) begin
                r_imem_addr    <= 32'(r_words_loaded) << 2;
                r_imem_wdata   <= w_packed_word;
                r_words_loaded <= r_words_loaded + 1'b1;
            end
            // halt_req freezes the count at the cycle it was seen in.
            if ((r_state == StRun) && !halt_req) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
        end
    end

    assign byte_ready   = w_byte_ready;
    assign imem_we      = r_imem_we;
    assign imem_addr    = r_imem_addr;
    assign imem_wdata   = r_imem_wdata;
    assign cpu_reset    = (r_state == StLoad) || (r_state == StFlush);
    assign cpu_enable   = (r_state == StRun);
    assign halted       = (r_state == StHalt);
    assign words_loaded = r_words_loaded;
    assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer. Two instances: a default-size one
// (IMEM_DEPTH=256, RUN_CYCLES=300) and a tiny one (IMEM_DEPTH=2, RUN_CYCLES=5).
// Expectations follow BOOT_SEQ_PARTIAL_WORD_EN when it is defined.
module tb_boot_sequencer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Main instance signals.
    logic        m_reset = 1'b1, m_valid = 1'b0, m_load_done = 1'b0, m_halt_req = 1'b0;
    logic [7:0]  m_data = 8'd0;
    logic        m_ready, m_we, m_cpu_reset, m_cpu_enable, m_halted;
    logic [31:0] m_addr, m_wdata;
    logic [8:0]  m_words, m_cycles;

    // Small instance signals.
    logic        s_reset = 1'b1, s_valid = 1'b0, s_load_done = 1'b0, s_halt_req = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        s_ready, s_we, s_cpu_reset, s_cpu_enable, s_halted;
    logic [31:0] s_addr, s_wdata;
    logic [1:0]  s_words;
    logic [2:0]  s_cycles;

    boot_sequencer #(.IMEM_DEPTH(256), .RUN_CYCLES(300)) dut (
        .clock(clock), .reset(m_reset), .byte_valid(m_valid), .byte_data(m_data),
        .byte_ready(m_ready), .load_done(m_load_done), .halt_req(m_halt_req),
        .imem_we(m_we), .imem_addr(m_addr), .imem_wdata(m_wdata),
        .cpu_reset(m_cpu_reset), .cpu_enable(m_cpu_enable), .halted(m_halted),
        .words_loaded(m_words), .cycle_count(m_cycles)
    );

    boot_sequencer #(.IMEM_DEPTH(2), .RUN_CYCLES(5)) dut_small (
        .clock(clock), .reset(s_reset), .byte_valid(s_valid), .byte_data(s_data),
        .byte_ready(s_ready), .load_done(s_load_done), .halt_req(s_halt_req),
        .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
        .cpu_reset(s_cpu_reset), .cpu_enable(s_cpu_enable), .halted(s_halted),
        .words_loaded(s_words), .cycle_count(s_cycles)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_log_addr[$];
    logic [31:0] m_log_data[$];
    logic [31:0] s_log_addr[$];
    logic [31:0] s_log_data[$];
    int          m_en_cnt = 0;
    int          s_acc_cnt = 0;

    // Write and activity monitors, sampled on the falling edge.
    always @(negedge clock) begin
        if (m_we) begin
            m_log_addr.push_back(m_addr);
            m_log_data.push_back(m_wdata);
        end
        if (s_we) begin
            s_log_addr.push_back(s_addr);
            s_log_data.push_back(s_wdata);
        end
        if (m_cpu_enable) m_en_cnt++;
        if (s_valid && s_ready) s_acc_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic m_step();
        @(posedge clock);
        #1;
    endtask

    task automatic m_do_reset();
        m_reset = 1'b1;
        m_valid = 1'b0;
        m_load_done = 1'b0;
        m_halt_req = 1'b0;
        m_step();
        m_step();
        m_reset = 1'b0;
        m_log_addr.delete();
        m_log_data.delete();
    endtask

    task automatic m_send(input logic [7:0] b);
        m_valid = 1'b1;
        m_data  = b;
        m_step();
        m_valid = 1'b0;
    endtask

    task automatic m_pulse_load_done();
        m_load_done = 1'b1;
        m_step();
        m_load_done = 1'b0;
    endtask

    logic [7:0] img_a[8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};

    initial begin
        // ---- Reset values ----
        m_do_reset();
        check_eq("rst_byte_ready", 32'(m_ready), 32'd1);
        check_eq("rst_imem_we", 32'(m_we), 32'd0);
        check_eq("rst_imem_addr", m_addr, 32'd0);
        check_eq("rst_imem_wdata", m_wdata, 32'd0);
        check_eq("rst_cpu_reset", 32'(m_cpu_reset), 32'd1);
        check_eq("rst_cpu_enable", 32'(m_cpu_enable), 32'd0);
        check_eq("rst_halted", 32'(m_halted), 32'd0);
        check_eq("rst_counts", 32'({m_words, m_cycles}), 32'd0);

        // ---- Two-word image, back-to-back bytes; then halt_req at RUN cycle 10 ----
        for (int i = 0; i < 8; i++) begin
            m_valid = 1'b1;
            m_data  = img_a[i];
            m_step();
            if (i == 3) begin
                check_eq("w0_latency_we", 32'(m_we), 32'd1);
                check_eq("w0_addr", m_addr, 32'h0);
                check_eq("w0_data", m_wdata, 32'h00500513);
            end
        end
        m_valid = 1'b0;
        m_pulse_load_done();
        check_eq("flush_cpu_reset", 32'(m_cpu_reset), 32'd1);
        check_eq("flush_byte_ready", 32'(m_ready), 32'd0);
        m_step();
        check_eq("run_cpu_reset", 32'(m_cpu_reset), 32'd0);
        check_eq("run_cpu_enable", 32'(m_cpu_enable), 32'd1);
        check_eq("a_nwrites", 32'(m_log_addr.size()), 32'd2);
        if (m_log_addr.size() == 2) begin
            check_eq("a_w1_addr", m_log_addr[1], 32'h4);
            check_eq("a_w1_data", m_log_data[1], 32'h00600593);
        end
        check_eq("a_words", 32'(m_words), 32'd2);
        repeat (10) m_step();
        check_eq("pre_halt_cycles", 32'(m_cycles), 32'd10);
        m_halt_req = 1'b1;
        m_step();
        m_halt_req = 1'b0;
        check_eq("hreq_halted", 32'(m_halted), 32'd1);
        check_eq("hreq_cycles", 32'(m_cycles), 32'd10);
        check_eq("hreq_cpu_enable", 32'(m_cpu_enable), 32'd0);
        check_eq("hreq_cpu_reset", 32'(m_cpu_reset), 32'd0);
        repeat (3) m_step();
        check_eq("halt_sticky", 32'({m_halted, m_cycles}), 32'({1'b1, 9'd10}));

        // ---- Reset after 3 bytes drops the partial word ----
        m_do_reset();
        m_send(8'hDE);
        m_send(8'hAD);
        m_send(8'hBE);
        m_do_reset();
        check_eq("midrst_words", 32'(m_words), 32'd0);
        m_send(8'h01);
        m_send(8'h02);
        m_send(8'h03);
        m_send(8'h04);
        m_step();
        check_eq("fresh_nwrites", 32'(m_log_addr.size()), 32'd1);
        if (m_log_addr.size() == 1) begin
            check_eq("fresh_addr", m_log_addr[0], 32'h0);
            check_eq("fresh_data", m_log_data[0], 32'h04030201);
        end

        // ---- 12-byte image, full 300-cycle run window ----
        m_do_reset();
        for (int i = 0; i < 12; i++) begin
            m_valid = 1'b1;
            m_data  = 8'(8'h10 + i);
            m_step();
        end
        m_valid = 1'b0;
        check_eq("c_words_b2b", 32'(m_words), 32'd3);
        m_en_cnt = 0;
        m_pulse_load_done();
        begin
            bit done = 1'b0;
            for (int i = 0; i < 400 && !done; i++) begin
                m_step();
                if (m_halted) done = 1'b1;
            end
            check_eq("c_halt_reached", 32'(done), 32'd1);
        end
        check_eq("c_enable_cycles", 32'(m_en_cnt), 32'd300);
        check_eq("c_cycle_count", 32'(m_cycles), 32'd300);
        if (m_log_addr.size() == 3) begin
            check_eq("c_w2_addr", m_log_addr[2], 32'h8);
            check_eq("c_w2_data", m_log_data[2], 32'h1B1A1918);
        end else begin
            check_eq("c_nwrites", 32'(m_log_addr.size()), 32'd3);
        end

        // ---- 6-byte image, last byte accepted with load_done ----
        m_do_reset();
        m_send(8'h11);
        m_send(8'h22);
        m_send(8'h33);
        m_send(8'h44);
        m_send(8'hAA);
        m_valid = 1'b1;
        m_data = 8'hBB;
        m_load_done = 1'b1;
        m_step();
        m_valid = 1'b0;
        m_load_done = 1'b0;
`ifdef BOOT_SEQ_PARTIAL_WORD_EN
        check_eq("d_flush_we", 32'(m_we), 32'd1);
        check_eq("d_flush_addr", m_addr, 32'h4);
        check_eq("d_flush_data", m_wdata, 32'h0000BBAA);
        check_eq("d_words", 32'(m_words), 32'd2);
        m_step();
        check_eq("d_nwrites", 32'(m_log_addr.size()), 32'd2);
`else
        check_eq("d_flush_we", 32'(m_we), 32'd0);
        check_eq("d_words", 32'(m_words), 32'd1);
        m_step();
        check_eq("d_nwrites", 32'(m_log_addr.size()), 32'd1);
`endif
        check_eq("d_w0_data", (m_log_data.size() > 0) ? m_log_data[0] : 32'hX, 32'h44332211);

        // ---- Small instance: memory fills after 8 of 12 offered bytes ----
        @(posedge clock);
        #1;
        s_reset = 1'b0;
        s_log_addr.delete();
        s_log_data.delete();
        s_acc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            s_valid = 1'b1;
            s_data  = 8'(i + 1);
            @(posedge clock);
            #1;
        end
        s_valid = 1'b0;
        check_eq("s_accepted", 32'(s_acc_cnt), 32'd8);
        check_eq("s_ready_full", 32'(s_ready), 32'd0);
        check_eq("s_words", 32'(s_words), 32'd2);
        check_eq("s_nwrites", 32'(s_log_addr.size()), 32'd2);
        if (s_log_addr.size() == 2) begin
            check_eq("s_w0", s_log_data[0], 32'h04030201);
            check_eq("s_w1_addr", s_log_addr[1], 32'h4);
            check_eq("s_w1", s_log_data[1], 32'h08070605);
        end
        s_load_done = 1'b1;
        @(posedge clock);
        #1;
        s_load_done = 1'b0;
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        check_eq("s_halted", 32'(s_halted), 32'd1);
        check_eq("s_cycles", 32'(s_cycles), 32'd5);
        s_load_done = 1'b1;
        @(posedge clock);
        #1;
        s_load_done = 1'b0;
        @(posedge clock);
        #1;
        check_eq("s_ld_ignored", 32'({s_halted, s_cpu_reset, s_words}), 32'({1'b1, 1'b0, 2'd2}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/boot_sequencer.md
# boot_sequencer

Sequencer sitting between the bench/host byte stream and `risc_v_cpu`. It loads a program image into the instruction memory, holds the core in reset while loading, then releases it for a bounded run and halts it. It owns the instruction-memory write port during load and gates the core's run window.

## Interface
Parameters:
- IMEM_DEPTH, 256, instruction memory size in 32-bit words.
- RUN_CYCLES, 300, length of the run window in clock cycles; must be ≥ 1.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  program image byte, in file order.
- byte_ready  out  1  sequencer accepts a byte this cycle.
- load_done  in  1  end-of-image marker, single-cycle pulse.
- halt_req  in  1  early stop request; only honoured in RUN.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  32  byte address of the written word (word index × 4).
- imem_wdata  out  32  little-endian word (first byte in [7:0]).
- cpu_reset  out  1  reset to risc_v_cpu.
- cpu_enable  out  1  core clock-enable; high only in RUN.
- halted  out  1  run window finished.
- words_loaded  out  $clog2(IMEM_DEPTH+1)  words written so far.
- cycle_count  out  $clog2(RUN_CYCLES+1)  RUN cycles elapsed.

## Operation
- States: LOAD, FLUSH, RUN, HALT. Reset → LOAD.
- LOAD: byte_ready = 1 unless words_loaded == IMEM_DEPTH. Each handshake (byte_valid & byte_ready) stores the byte into lane byte_idx (0..3). byte_idx increments and wraps after 3. The 4th byte completes a word.
- Word write: on the edge accepting the 4th byte, the following are registered: imem_wdata = {b3,b2,b1,b0}, imem_addr = words_loaded×4, imem_we = 1 for exactly one cycle. words_loaded increments on the same edge.
- Full: when words_loaded == IMEM_DEPTH, byte_ready = 0. Further bytes are not accepted. The FSM waits for load_done.
- load_done in LOAD → FLUSH. If a byte is accepted in the same cycle, it is included first. load_done outside LOAD is ignored.
- FLUSH: lasts exactly one cycle, with byte_ready = 0. Partial-word handling is described under Configuration. FLUSH → RUN.
- RUN: cpu_reset = 0 and cpu_enable = 1. cycle_count increments every cycle.
  - The edge on which cycle_count reaches RUN_CYCLES → HALT, so RUN lasts exactly RUN_CYCLES cycles.
  - halt_req = 1 → HALT on the next edge, with cycle_count frozen.
- HALT: cpu_enable = 0, cpu_reset = 0 (architectural state is preserved for inspection), halted = 1. HALT is terminal until reset.
- Reset mid-operation, in any state: the FSM returns to LOAD and byte_idx, words_loaded and cycle_count clear. Any pending imem_we is dropped. Memory contents are not cleared.

## Timing
- Values after the reset edge: byte_ready = 1, imem_we = 0, imem_addr = 0, imem_wdata = 0, cpu_reset = 1, cpu_enable = 0, halted = 0, words_loaded = 0, cycle_count = 0.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
- Write latency is one cycle from the 4th-byte handshake to imem_we.
- Back-to-back words sustain one byte per cycle.
- cpu_reset falls on the edge entering RUN: two edges after load_done is sampled.
- cpu_enable rises on the same edge that cpu_reset falls.

## Configuration
- BOOT_SEQ_PARTIAL_WORD_EN defined:
  - If byte_idx ≠ 0 when load_done is sampled and memory is not full, FLUSH asserts imem_we with unfilled lanes zeroed, at address words_loaded×4.
  - words_loaded increments.
- Not defined: trailing 1–3 bytes are discarded, and FLUSH performs no write.

## Structure
- Package boot_seq_pkg: state enum typedef (LOAD, FLUSH, RUN, HALT) and the state-width constant.
- Sub-module byte_packer: lane counter plus 32-bit assembly register. It provides word_complete, partial and clear inputs/outputs. The FSM stays in boot_sequencer.

## Test plan
- 8 bytes 0x13,0x05,0x50,0x00,0x93,0x05,0x60,0x00, then load_done → writes 0x00500513 @0x0 and 0x00600593 @0x4. cpu_reset falls 2 edges after load_done.
- Image of 12 bytes, RUN_CYCLES=300 → cpu_enable high for exactly 300 cycles, then halted = 1 and cycle_count = 300.
- IMEM_DEPTH=2, 12 bytes offered → two writes only. byte_ready = 0 after the 8th byte, and words_loaded = 2.
- 6 bytes then load_done:
  - With BOOT_SEQ_PARTIAL_WORD_EN: second write is 0x0000BBAA @0x4 (bytes AA, BB).
  - Without it: single write, words_loaded = 1.
- halt_req pulsed at RUN cycle 10 → HALT next edge, cycle_count = 10, cpu_enable = 0.
- Reset asserted after 3 bytes of a word → no imem_we. A fresh 4-byte load writes to address 0x0.
